// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates a read-only instruction port (I) and a read/write data port (D)
// onto a single main-memory command interface. Each access walks through
// IDLE -> ISSUE -> WAIT -> DONE, so one access completes every four cycles
// when memory answers on the first WAIT cycle. If memory never answers, the
// access is aborted after TIMEOUT WAIT cycles and completes with an error flag.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   i_req, i_addr       instruction read request (held until i_ack)
//   i_rdata, i_ack,     instruction read data, one-cycle completion pulse,
//   i_err               timeout flag (valid with i_ack)
//   d_req, d_we,        data request (held until d_ack), write enable,
//   d_addr, d_wdata     word address, write data
//   d_rdata, d_ack,     data read data, one-cycle completion pulse,
//   d_err               timeout flag (valid with d_ack)
//   mem_add,            memory address and write data
//   mem_write_data
//   mem_read, mem_write one-cycle memory commands (never both high)
//   mem_read_data,      memory read data and completion, registered in the
//   mem_ready           memory one cycle after a command
//   busy                high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned ADD_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_req,
    input  logic [ADD_WIDTH-1:0]  i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ack,
    output logic                  i_err,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADD_WIDTH-1:0]  d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  d_err,

    output logic [ADD_WIDTH-1:0]  mem_add,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_ready,

    output logic                  busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    // Counter value on the last WAIT cycle allowed before aborting.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;

    logic                  r_gnt_d;   // 1: the access in flight belongs to D
    logic                  r_last_d;  // port served most recently, 1: D
    logic                  r_we;
    logic [ADD_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [7:0]            r_cnt;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    logic                  w_any_req;
    logic                  w_pick_d;
    logic                  w_timeout;

    // -------------------------------------------------------------------------
    // Arbitration and next-state decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_any_req = i_req | d_req;
        // D wins when I is not asking, or when I was served last; this gives
        // strict alternation under sustained contention.
        w_pick_d  = d_req & (~i_req | ~r_last_d);
        // Readiness on the final allowed cycle still counts as success.
        w_timeout = (r_cnt == TimeoutLast) & ~mem_ready;

        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_any_req) w_state_next = StIssue;
            StIssue: w_state_next = StWait;
            StWait:  if (mem_ready || w_timeout) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Request latch: captured once in IDLE and held for the whole access, so
    // later port activity (including an early req drop) cannot disturb it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt_d <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == StIdle && w_any_req) begin
            r_gnt_d <= w_pick_d;
            // The instruction port can only read.
            r_we    <= w_pick_d & d_we;
            r_addr  <= w_pick_d ? d_addr : i_addr;
            r_wdata <= w_pick_d ? d_wdata : '0;
        end
    end

    // -------------------------------------------------------------------------
    // Timeout counter and error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            unique case (r_state)
                StIssue: begin
                    r_cnt <= 8'd0;
                    r_err <= 1'b0;
                end
                StWait: begin
                    if (mem_ready) begin
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                    r_err <= r_err;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Read data capture: only a successful read updates the owning port's
    // register; writes and timeouts leave both untouched.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if (r_state == StWait && mem_ready && !r_we) begin
            if (r_gnt_d) begin
                r_d_rdata <= mem_read_data;
            end else begin
                r_i_rdata <= mem_read_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Fairness memory: reset value I means the first contended grant goes to D.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_d <= 1'b0;
        end else if (r_state == StDone) begin
            r_last_d <= r_gnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: registers or decodes of registered state only
    // -------------------------------------------------------------------------
    always_comb begin
        busy           = (r_state != StIdle);
        mem_add        = r_addr;
        mem_write_data = r_wdata;
        mem_read       = (r_state == StIssue) & ~r_we;
        mem_write      = (r_state == StIssue) &  r_we;
        i_ack          = (r_state == StDone) & ~r_gnt_d;
        d_ack          = (r_state == StDone) &  r_gnt_d;
        i_err          = i_ack & r_err;
        d_err          = d_ack & r_err;
        i_rdata        = r_i_rdata;
        d_rdata        = r_d_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A behavioural memory with configurable
// response latency drives the memory side; a reference model (expected memory
// contents, expected read data per port, expected latency/error from the
// memory latency, expected grant order) predicts every observed result.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW      = 10;
    localparam int DW      = 32;
    localparam int TO      = 15;
    localparam int Words   = 1 << AW;
    localparam int MaxWait = 60;

    logic          clk;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          i_err;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          d_err;
    logic [AW-1:0] mem_add;
    logic [DW-1:0] mem_write_data;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_read_data;
    logic          mem_ready;
    logic          busy;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(
        .ADD_WIDTH  (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_rdata        (i_rdata),
        .i_ack          (i_ack),
        .i_err          (i_err),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_ack          (d_ack),
        .d_err          (d_err),
        .mem_add        (mem_add),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-on memory contents; word 5 is preset for the basic read scenario.
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        if (a == AW'(5)) return 32'hDEAD_BEEF;
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // ---------------------------------------------------------------------
    // Behavioural memory: ready arrives 1 + mem_lat cycles after a command;
    // a negative mem_lat means it never answers.
    // ---------------------------------------------------------------------
    logic [DW-1:0] mem_arr [Words];
    bit            mem_written [Words];
    int            mem_lat = 0;
    int            lat_left = 0;
    logic [AW-1:0] lat_addr = '0;

    always @(posedge clk) begin
        mem_ready <= 1'b0;
        if (mem_write) begin
            mem_arr[mem_add]     <= mem_write_data;
            mem_written[mem_add] <= 1'b1;
        end
        if (mem_read || mem_write) begin
            lat_left <= 0;
            if (mem_lat == 0) begin
                mem_ready     <= 1'b1;
                mem_read_data <= mem_written[mem_add] ? mem_arr[mem_add] : init_word(mem_add);
            end else if (mem_lat > 0) begin
                lat_left <= mem_lat;
                lat_addr <= mem_add;
            end
        end else if (lat_left > 0) begin
            lat_left <= lat_left - 1;
            if (lat_left == 1) begin
                mem_ready     <= 1'b1;
                mem_read_data <= mem_written[lat_addr] ? mem_arr[lat_addr] : init_word(lat_addr);
            end
        end
    end

    // Protocol monitor: counts illegal overlaps and every ack pulse.
    int viol    = 0;
    int n_i_ack = 0;
    int n_d_ack = 0;

    always @(negedge clk) begin
        viol    <= viol + int'(i_ack && d_ack) + int'(mem_read && mem_write);
        n_i_ack <= n_i_ack + int'(i_ack === 1'b1);
        n_d_ack <= n_d_ack + int'(d_ack === 1'b1);
    end

    // ---------------------------------------------------------------------
    // Reference model state
    // ---------------------------------------------------------------------
    logic [DW-1:0] ref_mem [Words];
    logic [DW-1:0] exp_i_rdata = '0;
    logic [DW-1:0] exp_d_rdata = '0;
    int            exp_i_acks = 0;
    int            exp_d_acks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
    endtask

    // One complete access from an idle arbiter on one port, checked against
    // the model. lat selects the memory response delay for this access.
    task automatic run_single(input string name, input bit is_d, input bit we,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input int lat);
        int            exp_lat;
        bit            exp_err;
        int            seen;
        int            ncmd;
        bit            cmd_ok;
        logic          got_err;
        logic [DW-1:0] got_rd;
        logic [DW-1:0] got_other;
        logic [DW-1:0] exp_own;
        logic [DW-1:0] exp_other;

        exp_err = (lat < 0) || (lat >= TO);
        exp_lat = exp_err ? TO + 2 : 3 + lat;
        mem_lat = lat;
        seen    = -1;
        ncmd    = 0;
        cmd_ok  = 1'b1;
        got_err = 1'b0;
        got_rd  = '0;
        got_other = '0;

        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end

        for (int c = 0; c < MaxWait; c++) begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                ncmd++;
                if (mem_add !== addr || mem_write !== (is_d & we) ||
                    (is_d && we && mem_write_data !== wdata)) cmd_ok = 1'b0;
            end
            if ((is_d ? d_ack : i_ack) === 1'b1) begin
                seen      = c;
                got_err   = is_d ? d_err : i_err;
                got_rd    = is_d ? d_rdata : i_rdata;
                got_other = is_d ? i_rdata : d_rdata;
                break;
            end
            tick();
        end
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;

        // Model update
        if (!exp_err && we)  ref_mem[addr] = wdata;
        if (!exp_err && !we) begin
            if (is_d) exp_d_rdata = ref_mem[addr];
            else      exp_i_rdata = ref_mem[addr];
        end
        if (is_d) exp_d_acks++; else exp_i_acks++;
        exp_own   = is_d ? exp_d_rdata : exp_i_rdata;
        exp_other = is_d ? exp_i_rdata : exp_d_rdata;

        checks++;
        if (seen != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, want %0d", name, seen, exp_lat);
        end
        if (seen >= 0) begin
            checks++;
            if (got_err !== exp_err) begin
                errors++;
                $display("FAIL %s err: got %b, want %b", name, got_err, exp_err);
            end
            checks++;
            if (got_rd !== exp_own) begin
                errors++;
                $display("FAIL %s rdata: got %h, want %h", name, got_rd, exp_own);
            end
            checks++;
            if (got_other !== exp_other) begin
                errors++;
                $display("FAIL %s other-port rdata: got %h, want %h", name, got_other, exp_other);
            end
            checks++;
            if (ncmd != 1 || !cmd_ok) begin
                errors++;
                $display("FAIL %s mem command: got %0d cmds ok=%0b, want 1 cmd ok=1",
                         name, ncmd, cmd_ok);
            end
        end
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        #1;
        checks++;
        if ({busy, i_ack, d_ack, i_err, d_err, mem_read, mem_write} !== 7'b0) begin
            errors++;
            $display("FAIL reset controls: got %b, want 0000000",
                     {busy, i_ack, d_ack, i_err, d_err, mem_read, mem_write});
        end
        checks++;
        if (mem_add !== '0 || mem_write_data !== '0) begin
            errors++;
            $display("FAIL reset mem bus: got add=%h wdata=%h, want 0", mem_add, mem_write_data);
        end
        checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL reset rdata: got i=%h d=%h, want 0", i_rdata, d_rdata);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle after reset busy: got %b, want 0", busy);
        end
    endtask

    task automatic test_i_read();
        i_req = 1'b1; i_addr = AW'(5); mem_lat = 0;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_add !== AW'(5) || busy !== 1'b1) begin
            errors++;
            $display("FAIL i_read issue: got rd=%b wr=%b add=%h busy=%b, want 1 0 005 1",
                     mem_read, mem_write, mem_add, busy);
        end
        tick();
        i_addr = AW'($urandom_range(0, Words - 1));
        @(negedge clk);
        checks++;
        if (i_ack !== 1'b0) begin
            errors++;
            $display("FAIL i_read early ack: got %b, want 0", i_ack);
        end
        tick();
        @(negedge clk);
        checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'hDEAD_BEEF || i_err !== 1'b0 || d_ack !== 1'b0) begin
            errors++;
            $display("FAIL i_read done: got ack=%b rdata=%h err=%b d_ack=%b, want 1 deadbeef 0 0",
                     i_ack, i_rdata, i_err, d_ack);
        end
        tick();
        i_req = 1'b0;
        exp_i_rdata = ref_mem[5];
        exp_i_acks++;
    endtask

    task automatic test_d_write_read();
        run_single("d_write", 1'b1, 1'b1, AW'(10'h3FF), 32'h1234_5678, 0);
        run_single("d_read", 1'b1, 1'b0, AW'(10'h3FF), '0, 0);
        checks++;
        if (d_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL d_write_read value: got %h, want 12345678", d_rdata);
        end
    endtask

    task automatic test_contention();
        bit            exp_port;
        int            nack;
        bit            acked;
        bit            acked_d;
        logic [DW-1:0] exp_rd;
        do_reset();
        mem_lat = 0;
        i_addr = AW'($urandom_range(0, Words - 1));
        d_addr = AW'($urandom_range(0, Words - 1));
        d_we   = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        exp_port = 1'b1;  // fairness register starts at I, so D goes first
        nack = 0;
        for (int c = 0; c < MaxWait && nack < 4; c++) begin
            @(negedge clk);
            acked   = (i_ack === 1'b1) || (d_ack === 1'b1);
            acked_d = (d_ack === 1'b1);
            if (acked) begin
                exp_rd = exp_port ? ref_mem[d_addr] : ref_mem[i_addr];
                checks++;
                if (acked_d !== exp_port) begin
                    errors++;
                    $display("FAIL contention order #%0d: got d_ack=%b, want %b",
                             nack, acked_d, exp_port);
                end
                checks++;
                if (c != 3 + 4 * nack) begin
                    errors++;
                    $display("FAIL contention timing #%0d: got cycle %0d, want %0d",
                             nack, c, 3 + 4 * nack);
                end
                checks++;
                if ((exp_port ? d_rdata : i_rdata) !== exp_rd) begin
                    errors++;
                    $display("FAIL contention rdata #%0d: got %h, want %h",
                             nack, exp_port ? d_rdata : i_rdata, exp_rd);
                end
                if (exp_port) begin exp_d_rdata = exp_rd; exp_d_acks++; end
                else          begin exp_i_rdata = exp_rd; exp_i_acks++; end
                exp_port = ~exp_port;
                nack++;
            end
            tick();
            if (acked) begin
                if (acked_d) d_addr = AW'($urandom_range(0, Words - 1));
                else         i_addr = AW'($urandom_range(0, Words - 1));
            end
            if (nack == 4) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        checks++;
        if (nack != 4) begin
            errors++;
            $display("FAIL contention ack count: got %0d, want 4", nack);
        end
    endtask

    task automatic test_timeout();
        run_single("d_timeout", 1'b1, 1'b0, AW'($urandom_range(0, Words - 1)), '0, -1);
        run_single("wait_last_cycle", 1'b1, 1'b0, AW'($urandom_range(0, Words - 1)), '0, TO - 1);
        run_single("i_ready_too_late", 1'b0, 1'b0, AW'($urandom_range(0, Words - 1)), '0, TO);
    endtask

    task automatic test_reset_in_wait();
        int acks_before;
        i_req = 1'b1; i_addr = AW'($urandom_range(0, Words - 1)); mem_lat = -1;
        tick();
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_wait busy before: got %b, want 1", busy);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({busy, i_ack, d_ack, i_err, d_err, mem_read, mem_write} !== 7'b0 ||
            mem_add !== '0 || mem_write_data !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL reset_in_wait outputs: got ctl=%b add=%h wd=%h ir=%h dr=%h, want 0",
                     {busy, i_ack, d_ack, i_err, d_err, mem_read, mem_write},
                     mem_add, mem_write_data, i_rdata, d_rdata);
        end
        i_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        mem_lat = 0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        acks_before = n_i_ack + n_d_ack;
        repeat (8) tick();
        checks++;
        if (n_i_ack + n_d_ack != acks_before || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait stray ack: got %0d new acks busy=%b, want 0 0",
                     n_i_ack + n_d_ack - acks_before, busy);
        end
    endtask

    task automatic test_early_drop();
        int seen;
        d_req = 1'b1; d_we = 1'b0; d_addr = AW'(7); mem_lat = 0;
        tick();
        d_req = 1'b0; d_addr = AW'(10'h2A); d_we = 1'b1; d_wdata = DW'($urandom);
        @(negedge clk);
        checks++;
        if (mem_add !== AW'(7) || mem_read !== 1'b1 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL early_drop issue: got add=%h rd=%b wr=%b, want 007 1 0",
                     mem_add, mem_read, mem_write);
        end
        seen = -1;
        for (int c = 1; c < MaxWait; c++) begin
            if (d_ack === 1'b1) begin
                seen = c;
                break;
            end
            tick();
            @(negedge clk);
        end
        exp_d_rdata = ref_mem[7];
        exp_d_acks++;
        checks++;
        if (seen != 3 || d_rdata !== exp_d_rdata) begin
            errors++;
            $display("FAIL early_drop ack: got cycle %0d rdata %h, want 3 %h",
                     seen, d_rdata, exp_d_rdata);
        end
        tick();
        d_we = 1'b0;
    endtask

    task automatic test_random();
        bit            is_d;
        bit            we;
        int            r;
        int            lat;
        logic [AW-1:0] addr;
        for (int n = 0; n < 40; n++) begin
            is_d = 1'($urandom_range(0, 1));
            we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            // Reuse a small address pool so reads often hit earlier writes.
            addr = AW'($urandom_range(0, 15) * 61);
            r    = int'($urandom_range(0, 9));
            if (r < 6)       lat = 0;
            else if (r < 8)  lat = int'($urandom_range(1, TO - 1));
            else if (we)     lat = int'($urandom_range(0, TO - 1));
            else if (r == 8) lat = TO;
            else             lat = -1;
            run_single("random", is_d, we, addr, DW'($urandom), lat);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL overlap: got %0d cycles with both acks or both commands, want 0", viol);
        end
        checks++;
        if (n_i_ack != exp_i_acks) begin
            errors++;
            $display("FAIL i_ack count: got %0d, want %0d", n_i_ack, exp_i_acks);
        end
        checks++;
        if (n_d_ack != exp_d_acks) begin
            errors++;
            $display("FAIL d_ack count: got %0d, want %0d", n_d_ack, exp_d_acks);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int a = 0; a < Words; a++) ref_mem[a] = init_word(AW'(a));
        test_reset();
        test_i_read();
        test_d_write_read();
        test_contention();
        test_timeout();
        test_reset_in_wait();
        test_early_drop();
        test_random();
        tick();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
